bus_arbiter: RTL

- Registered, parametrised bus arbiter; successor to the combinational 8-input priority encoder.
- Accepts N_REQ request lines from bus masters and issues one-hot grants plus a binary index and valid flag.
- Ownership is held until the owner drops its request.
- Selectable fixed (lowest index wins) or round-robin priority; sits between master request lines and the bus mux select.

---
 rtl/bus_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: registered N_REQ-input bus arbiter with hold-until-release
// ownership, a one-cycle turnaround gap between owners, and selectable fixed
// (lowest index wins) or round-robin priority.
//
// Optional feature macro: BUS_ARB_TIMEOUT_EN
//   When defined, an owner that keeps its request high for TIMEOUT_CYC
//   consecutive owned cycles is forcibly released, timeout_err pulses for one
//   cycle, and the evicted master is kept out of arbitration until its
//   request has been seen low at least once.
//   When undefined, grants are held indefinitely and timeout_err is tied 0.
module bus_arbiter #(
    parameter int N_REQ       = 8,
    parameter int RR_MODE     = 0,
    parameter int TIMEOUT_CYC = 256,
    localparam int IDX_W      = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;

    logic [N_REQ-1:0] r_grant;
    logic [IDX_W-1:0] r_grantIdx;
    logic             r_grantValid;
    logic [IDX_W-1:0] r_lastIdx;

    logic [N_REQ-1:0] w_eligible;
    logic             w_anyEligible;
    logic [IDX_W-1:0] w_fixIdx;
    logic [IDX_W-1:0] w_rrIdx;
    logic [IDX_W-1:0] w_winIdx;
    logic             w_ownerReq;
    logic             w_loadGrant;
    logic             w_release;
    logic             w_forced;
    logic             w_timeoutHit;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_holdCnt;
    logic [N_REQ-1:0] r_mask;
    logic             r_timeoutErr;

    // An evicted master stays invisible to arbitration until it drops req.
    assign w_eligible   = req & ~r_mask;
    // The limit is hit on the edge that would complete the TIMEOUT_CYC-th owned cycle.
    assign w_timeoutHit = (r_state == BUSY) && w_ownerReq &&
                          (r_holdCnt == CNT_W'(TIMEOUT_CYC - 1));
    assign timeout_err  = r_timeoutErr;
`else
    assign w_eligible   = req;
    assign w_timeoutHit = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    assign w_anyEligible = |w_eligible;
    assign w_ownerReq    = req[r_grantIdx];
    assign w_winIdx      = (RR_MODE != 0) ? w_rrIdx : w_fixIdx;

    assign grant       = r_grant;
    assign grant_idx   = r_grantIdx;
    assign grant_valid = r_grantValid;

    // Fixed priority: scan from the top down so the lowest set index is the last one written.
    always_comb begin
        logic [IDX_W-1:0] candIdx;
        w_fixIdx = '0;
        candIdx  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            candIdx = IDX_W'(i);
            if (w_eligible[candIdx]) begin
                w_fixIdx = candIdx;
            end
        end
    end

    // Round-robin: search upward from the slot after the last winner, wrapping, first hit wins.
    always_comb begin
        logic             found;
        int               cand;
        logic [IDX_W-1:0] candIdx;
        w_rrIdx = '0;
        found   = 1'b0;
        cand    = 0;
        candIdx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(r_lastIdx) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            candIdx = IDX_W'(cand);
            if (!found && w_eligible[candIdx]) begin
                found   = 1'b1;
                w_rrIdx = candIdx;
            end
        end
    end

    // State register; reset wins over everything, including an active grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: arbitrate in IDLE and TURN, hold in BUSY until release or timeout.
    always_comb begin
        w_nextState = r_state;
        w_loadGrant = 1'b0;
        w_release   = 1'b0;
        w_forced    = 1'b0;
        case (r_state)
            IDLE, TURN: begin
                if (w_anyEligible) begin
                    w_loadGrant = 1'b1;
                    w_nextState = BUSY;
                end else begin
                    w_nextState = IDLE;
                end
            end
            BUSY: begin
                if (!w_ownerReq) begin
                    w_release   = 1'b1;
                    w_nextState = TURN;
                end else if (w_timeoutHit) begin
                    w_release   = 1'b1;
                    w_forced    = 1'b1;
                    w_nextState = TURN;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Grant outputs are loaded on a win and cleared on any release, otherwise held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= '0;
            r_grantIdx   <= '0;
            r_grantValid <= 1'b0;
        end else if (w_loadGrant) begin
            r_grant      <= N_REQ'(1) << w_winIdx;
            r_grantIdx   <= w_winIdx;
            r_grantValid <= 1'b1;
        end else if (w_release) begin
            r_grant      <= '0;
            r_grantIdx   <= '0;
            r_grantValid <= 1'b0;
        end
    end

    // Last winner pointer; resetting to the top index puts index 0 first in line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lastIdx <= IDX_W'(N_REQ - 1);
        end else if (w_loadGrant) begin
            r_lastIdx <= w_winIdx;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    // Hold counter restarts on each new grant and counts owned cycles that do not end in release.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_holdCnt <= '0;
        end else if (w_loadGrant) begin
            r_holdCnt <= '0;
        end else if ((r_state == BUSY) && !w_release) begin
            r_holdCnt <= r_holdCnt + CNT_W'(1);
        end
    end

    // Eviction mask: set for the evicted owner, cleared once that master's req is seen low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '0;
        end else begin
            r_mask <= (r_mask & req) | (w_forced ? r_grant : '0);
        end
    end

    // Error pulse accompanies the first zero-grant cycle after a forced release.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeoutErr <= 1'b0;
        end else begin
            r_timeoutErr <= w_forced;
        end
    end
`endif

endmodule
